// File: rtl/led_status_pkg.sv
// Shared types and constants for the multi-channel LED status controller.
// Contents: config field widths, mode/state enums, config payload struct,
// flash gap multiplier and a constant-foldable clog2 helper.
package led_status_pkg;

  localparam int unsigned CH_W     = 4;
  localparam int unsigned MODE_W   = 3;
  localparam int unsigned PERIOD_W = 16;
  localparam int unsigned COUNT_W  = 4;
  localparam int unsigned MS_W     = 18;  // holds GAP_MULT * 65535 without overflow
  localparam int unsigned GAP_MULT = 4;

  // Channel modes as written on cfg_mode; 5..7 are reserved.
  typedef enum logic [MODE_W-1:0] {
    MODE_OFF     = 3'd0,
    MODE_ON      = 3'd1,
    MODE_BLINK   = 3'd2,
    MODE_FLASH   = 3'd3,
    MODE_BREATHE = 3'd4
  } mode_e;

  // Per-channel FSM states.
  typedef enum logic [2:0] {
    S_OFF,
    S_ON,
    S_BLINK,
    S_FLASH_ON,
    S_FLASH_OFF,
    S_GAP,
    S_BREATHE
  } chan_state_e;

  // Config payload delivered to a channel on a write.
  typedef struct packed {
    mode_e                 mode;
    logic [PERIOD_W-1:0]   period_ms;
    logic [COUNT_W-1:0]    count;
  } chan_cfg_t;

  // Ceiling log2, minimum 1, for sizing counters from parameters.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((33'd1 << i) < 33'(value)) result = i + 1;
    end
    return (result == 0) ? 1 : result;
  endfunction

endpackage

// File: rtl/led_chan_fsm.sv
// One LED channel: stored config, ms counter, flash index, blink phase and
// the pattern FSM. Outputs are next-cycle values that the top registers at
// the pin, so a config write shows on led one cycle after cfg_wr.
// Build option: LED_BREATHE_EN adds the triangle duty ramp (S_BREATHE).
// Ports:
//   clk, rst_n  clock, async active-low reset
//   tick        1 ms strobe from the shared prescaler
//   cfg_wr      config write for this channel (wins over tick)
//   cfg         mode / period / count payload
//   pwm_cnt     shared PWM counter (only used with LED_BREATHE_EN)
//   lit_c       next value of the lit state (polarity-free)
//   done_c      next value of the end-of-sequence pulse
module led_chan_fsm
  import led_status_pkg::*;
#(
  parameter int unsigned PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                tick,
  input  logic                cfg_wr,
  input  chan_cfg_t           cfg,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  output logic                lit_c,
  output logic                done_c
);

  chan_state_e         state_q, state_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic [COUNT_W-1:0]  count_q, count_d;
  logic [MS_W-1:0]     ms_q, ms_d;
  logic [COUNT_W-1:0]  idx_q, idx_d;
  logic                phase_q, phase_d;

  logic [PERIOD_W-1:0] per_eff;
  logic [PERIOD_W-1:0] per_m1;
  logic [MS_W-1:0]     gap_m1;
  logic [MS_W-1:0]     ms_inc;
  logic                phase_end;
  logic                gap_end;

  // A zero period behaves as 1 ms.
  assign per_eff   = (period_q == '0) ? PERIOD_W'(1) : period_q;
  assign per_m1    = per_eff - PERIOD_W'(1);
  assign gap_m1    = MS_W'(GAP_MULT) * MS_W'(per_eff) - MS_W'(1);
  assign ms_inc    = ms_q + MS_W'(1);
  assign phase_end = (ms_q == MS_W'(per_m1));
  assign gap_end   = (ms_q == gap_m1);

`ifdef LED_BREATHE_EN
  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic                up_q, up_d;

  // Breathe duty ramp registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_q <= '0;
      up_q   <= 1'b1;
    end else begin
      duty_q <= duty_d;
      up_q   <= up_d;
    end
  end
`else
  logic unused_pwm;
  assign unused_pwm = ^pwm_cnt;
`endif

  // State and channel registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_OFF;
      period_q <= '0;
      count_q  <= '0;
      ms_q     <= '0;
      idx_q    <= '0;
      phase_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      period_q <= period_d;
      count_q  <= count_d;
      ms_q     <= ms_d;
      idx_q    <= idx_d;
      phase_q  <= phase_d;
    end
  end

  // Next state: a config write restarts the channel and swallows any tick.
  always_comb begin
    state_d  = state_q;
    period_d = period_q;
    count_d  = count_q;
    ms_d     = ms_q;
    idx_d    = idx_q;
    phase_d  = phase_q;
    done_c   = 1'b0;
`ifdef LED_BREATHE_EN
    duty_d   = duty_q;
    up_d     = up_q;
`endif
    if (cfg_wr) begin
      period_d = cfg.period_ms;
      count_d  = cfg.count;
      ms_d     = '0;
      idx_d    = '0;
      phase_d  = 1'b0;
`ifdef LED_BREATHE_EN
      duty_d   = '0;
      up_d     = 1'b1;
`endif
      case (cfg.mode)
        MODE_ON:      state_d = S_ON;
        MODE_BLINK:   state_d = S_BLINK;
        MODE_FLASH:   state_d = (cfg.count == '0) ? S_OFF : S_FLASH_ON;
`ifdef LED_BREATHE_EN
        MODE_BREATHE: state_d = S_BREATHE;
`endif
        default:      state_d = S_OFF;
      endcase
    end else if (tick) begin
      case (state_q)
        S_BLINK: begin
          if (phase_end) begin
            ms_d    = '0;
            phase_d = ~phase_q;
          end else begin
            ms_d = ms_inc;
          end
        end
        S_FLASH_ON: begin
          if (phase_end) begin
            ms_d    = '0;
            state_d = S_FLASH_OFF;
          end else begin
            ms_d = ms_inc;
          end
        end
        S_FLASH_OFF: begin
          if (phase_end) begin
            ms_d = '0;
            if (idx_q == count_q - COUNT_W'(1)) begin
              idx_d   = '0;
              state_d = S_GAP;
            end else begin
              idx_d   = idx_q + COUNT_W'(1);
              state_d = S_FLASH_ON;
            end
          end else begin
            ms_d = ms_inc;
          end
        end
        S_GAP: begin
          if (gap_end) begin
            ms_d    = '0;
            done_c  = 1'b1;
            state_d = S_FLASH_ON;
          end else begin
            ms_d = ms_inc;
          end
        end
`ifdef LED_BREATHE_EN
        // Triangle 0 -> max -> 0, one step per ms.
        S_BREATHE: begin
          if (up_q) begin
            if (duty_q == '1) begin
              up_d   = 1'b0;
              duty_d = duty_q - PWM_BITS'(1);
            end else begin
              duty_d = duty_q + PWM_BITS'(1);
            end
          end else begin
            if (duty_q == '0) begin
              up_d   = 1'b1;
              duty_d = PWM_BITS'(1);
            end else begin
              duty_d = duty_q - PWM_BITS'(1);
            end
          end
        end
`endif
        default: ;
      endcase
    end
  end

  // Lit decode from the next state so the pin register tracks it directly.
  always_comb begin
    lit_c = 1'b0;
    case (state_d)
      S_ON, S_FLASH_ON: lit_c = 1'b1;
      S_BLINK:          lit_c = ~phase_d;
`ifdef LED_BREATHE_EN
      S_BREATHE:        lit_c = (pwm_cnt < duty_d);
`endif
      default:          lit_c = 1'b0;
    endcase
  end

endmodule

// File: rtl/led_status_ctrl.sv
// Multi-channel LED pattern generator (off / on / blink / flash-code).
// Owns the free-running 1 ms prescaler, config write decode and the output
// pin registers; each channel's pattern lives in led_chan_fsm.
// Build option: LED_BREATHE_EN enables mode 4 (BREATHE) and the shared PWM
// counter; without it mode 4 is stored as OFF.
// Ports:
//   clk, rst_n     clock, async active-low reset
//   cfg_valid      one-cycle config write strobe
//   cfg_ch         target channel (writes to cfg_ch >= NUM_LEDS ignored)
//   cfg_mode       0 OFF, 1 ON, 2 BLINK, 3 FLASH, 4 BREATHE, 5..7 -> OFF
//   cfg_period_ms  blink half-period / flash on and off time (0 acts as 1)
//   cfg_count      number of flashes per FLASH sequence (0 acts as OFF)
//   led            registered LED drive, polarity set by ACTIVE_HIGH
//   seq_done       one-cycle pulse per channel at the end of a FLASH gap
module led_status_ctrl
  import led_status_pkg::*;
#(
  parameter int unsigned CLOCK_MHZ   = 27,
  parameter int unsigned NUM_LEDS    = 4,
  parameter int unsigned ACTIVE_HIGH = 1,
  parameter int unsigned PWM_BITS    = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_valid,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [MODE_W-1:0]   cfg_mode,
  input  logic [PERIOD_W-1:0] cfg_period_ms,
  input  logic [COUNT_W-1:0]  cfg_count,
  output logic [NUM_LEDS-1:0] led,
  output logic [NUM_LEDS-1:0] seq_done
);

  localparam int unsigned TICK_CYCLES = CLOCK_MHZ * 1000;
  localparam int unsigned PRE_W       = clog2(TICK_CYCLES);
  localparam int unsigned CH_CMP_W    = CH_W + 1;
  localparam logic [NUM_LEDS-1:0] UNLIT = (ACTIVE_HIGH != 0) ? {NUM_LEDS{1'b0}}
                                                             : {NUM_LEDS{1'b1}};

  logic [PRE_W-1:0]    pre_q;
  logic                tick_c;
  logic                cfg_hit_c;
  chan_cfg_t           cfg_c;
  logic [NUM_LEDS-1:0] wr_c;
  logic [NUM_LEDS-1:0] lit_c;
  logic [NUM_LEDS-1:0] done_c;
  logic [PWM_BITS-1:0] pwm_cnt_c;

  // Free-running ms prescaler; config writes never disturb it.
  assign tick_c = (pre_q == PRE_W'(TICK_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      pre_q <= '0;
    else if (tick_c) pre_q <= '0;
    else             pre_q <= pre_q + PRE_W'(1);
  end

`ifdef LED_BREATHE_EN
  logic [PWM_BITS-1:0] pwm_q;

  // Shared PWM ramp compared against each channel's duty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pwm_q <= '0;
    else        pwm_q <= pwm_q + PWM_BITS'(1);
  end

  assign pwm_cnt_c = pwm_q;
`else
  assign pwm_cnt_c = '0;
`endif

  // Extra bit keeps the range check correct when NUM_LEDS is 16.
  assign cfg_hit_c = cfg_valid && ({1'b0, cfg_ch} < CH_CMP_W'(NUM_LEDS));
  assign cfg_c     = chan_cfg_t'{mode_e'(cfg_mode), cfg_period_ms, cfg_count};

  for (genvar i = 0; i < NUM_LEDS; i++) begin : g_chan
    assign wr_c[i] = cfg_hit_c && (cfg_ch == CH_W'(i));

    led_chan_fsm #(
      .PWM_BITS (PWM_BITS)
    ) u_chan (
      .clk     (clk),
      .rst_n   (rst_n),
      .tick    (tick_c),
      .cfg_wr  (wr_c[i]),
      .cfg     (cfg_c),
      .pwm_cnt (pwm_cnt_c),
      .lit_c   (lit_c[i]),
      .done_c  (done_c[i])
    );
  end

  // Pin registers; XOR with the unlit level applies polarity.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led      <= UNLIT;
      seq_done <= '0;
    end else begin
      led      <= lit_c ^ UNLIT;
      seq_done <= done_c;
    end
  end

endmodule

// File: tb/tb_led_status_ctrl.sv
// Directed bench for led_status_ctrl at CLOCK_MHZ=1 (1 ms = 1000 clk).
// Vectors name the posedge (counted from reset release) at which a config
// is sampled and the led / seq_done values expected just after that edge.
module tb_led_status_ctrl;

  typedef struct {
    int unsigned t;
    logic        v;
    logic [3:0]  ch;
    logic [2:0]  mode;
    logic [15:0] per;
    logic [3:0]  cnt;
    logic [3:0]  led;
    logic [3:0]  done;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_valid = 1'b0;
  logic [3:0]  cfg_ch = '0;
  logic [2:0]  cfg_mode = '0;
  logic [15:0] cfg_period_ms = '0;
  logic [3:0]  cfg_count = '0;
  logic [3:0]  led, seq_done, led_n, seq_done_n;

  int checks = 0;
  int errors = 0;
  int unsigned edge_cnt;
  vec_t vecs[$];

  led_status_ctrl #(.CLOCK_MHZ(1), .NUM_LEDS(4), .ACTIVE_HIGH(1), .PWM_BITS(8)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ch(cfg_ch),
    .cfg_mode(cfg_mode), .cfg_period_ms(cfg_period_ms), .cfg_count(cfg_count),
    .led(led), .seq_done(seq_done));

  led_status_ctrl #(.CLOCK_MHZ(1), .NUM_LEDS(4), .ACTIVE_HIGH(0), .PWM_BITS(8)) dut_n (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ch(cfg_ch),
    .cfg_mode(cfg_mode), .cfg_period_ms(cfg_period_ms), .cfg_count(cfg_count),
    .led(led_n), .seq_done(seq_done_n));

`ifdef LED_BREATHE_EN
  logic [3:0] led_b, seq_done_b;

  led_status_ctrl #(.CLOCK_MHZ(1), .NUM_LEDS(4), .ACTIVE_HIGH(1), .PWM_BITS(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ch(cfg_ch),
    .cfg_mode(cfg_mode), .cfg_period_ms(cfg_period_ms), .cfg_count(cfg_count),
    .led(led_b), .seq_done(seq_done_b));
`endif

  always #5 clk = ~clk;

  // Edge number since reset release; matches the prescaler phase.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edge_cnt <= 0;
    else        edge_cnt <= edge_cnt + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic add_vec(input int unsigned t, input logic v, input logic [3:0] ch,
                         input logic [2:0] mode, input logic [15:0] per,
                         input logic [3:0] cnt, input logic [3:0] exp_led,
                         input logic [3:0] exp_done);
    vec_t r;
    r.t = t; r.v = v; r.ch = ch; r.mode = mode; r.per = per; r.cnt = cnt;
    r.led = exp_led; r.done = exp_done;
    vecs.push_back(r);
  endtask

  task automatic check4(input string name, input int unsigned t,
                        input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %b expected %b", name, t, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic run_vecs();
    for (int i = 0; i < vecs.size(); i++) begin
      while (edge_cnt + 1 < vecs[i].t) @(negedge clk);
      cfg_valid     = vecs[i].v;
      cfg_ch        = vecs[i].ch;
      cfg_mode      = vecs[i].mode;
      cfg_period_ms = vecs[i].per;
      cfg_count     = vecs[i].cnt;
      @(posedge clk);
      #1;
      cfg_valid = 1'b0;
      check4("led", vecs[i].t, led, vecs[i].led);
      check4("seq_done", vecs[i].t, seq_done, vecs[i].done);
      check4("led_inv", vecs[i].t, led_n, ~vecs[i].led);
      check4("seq_done_inv", vecs[i].t, seq_done_n, vecs[i].done);
    end
  endtask

`ifdef LED_BREATHE_EN
  task automatic lit_cycles(output int n);
    n = 0;
    repeat (16) begin
      @(posedge clk);
      #1;
      if (led_b[0]) n++;
    end
  endtask
`endif

  initial begin
    int n;
    repeat (3) @(negedge clk);
    check4("reset_led", 0, led, 4'b0000);
    check4("reset_seq_done", 0, seq_done, 4'b0000);
    check4("reset_led_inv", 0, led_n, 4'b1111);
    check4("reset_seq_done_inv", 0, seq_done_n, 4'b0000);
    rst_n = 1'b1;

    //       edge   v   ch     mode  per  cnt  led      done
    add_vec(   10, 1, 4'd0,  3'd2, 3, 0, 4'b0001, 4'b0000); // ch0 BLINK 3 ms
    add_vec(   20, 1, 4'd2,  3'd2, 0, 0, 4'b0101, 4'b0000); // ch2 BLINK period 0
    add_vec(   30, 1, 4'd1,  3'd3, 2, 2, 4'b0111, 4'b0000); // ch1 FLASH x2, 2 ms
    add_vec(   40, 1, 4'd3,  3'd1, 0, 0, 4'b1111, 4'b0000); // ch3 ON
    add_vec(  999, 0, 4'd0,  3'd0, 0, 0, 4'b1111, 4'b0000); // no tick yet
    add_vec( 1000, 0, 4'd0,  3'd0, 0, 0, 4'b1011, 4'b0000); // first tick: ch2 toggles
    add_vec( 1999, 0, 4'd0,  3'd0, 0, 0, 4'b1011, 4'b0000);
    add_vec( 2000, 0, 4'd0,  3'd0, 0, 0, 4'b1101, 4'b0000); // ch1 off, ch2 on
    add_vec( 2500, 1, 4'd2,  3'd6, 0, 0, 4'b1001, 4'b0000); // reserved mode -> OFF
    add_vec( 2999, 0, 4'd0,  3'd0, 0, 0, 4'b1001, 4'b0000);
    add_vec( 3000, 0, 4'd0,  3'd0, 0, 0, 4'b1000, 4'b0000); // ch0 toggles off
    add_vec( 4000, 0, 4'd0,  3'd0, 0, 0, 4'b1010, 4'b0000); // ch1 second flash
    add_vec( 5000, 1, 4'd0,  3'd2, 3, 0, 4'b1011, 4'b0000); // cfg on a tick edge
    add_vec( 6000, 0, 4'd0,  3'd0, 0, 0, 4'b1001, 4'b0000); // ch1 off, ch0 holds
    add_vec( 7000, 0, 4'd0,  3'd0, 0, 0, 4'b1001, 4'b0000); // tick was discarded
    add_vec( 7500, 1, 4'd15, 3'd1, 0, 0, 4'b1001, 4'b0000); // out-of-range channel
    add_vec( 7999, 0, 4'd0,  3'd0, 0, 0, 4'b1001, 4'b0000);
    add_vec( 8000, 0, 4'd0,  3'd0, 0, 0, 4'b1000, 4'b0000); // ch0 toggles off
    add_vec( 9500, 1, 4'd3,  3'd3, 5, 0, 4'b0000, 4'b0000); // FLASH count 0 -> OFF
    add_vec(11000, 0, 4'd0,  3'd0, 0, 0, 4'b0001, 4'b0000);
    add_vec(11200, 1, 4'd2,  3'd1, 0, 0, 4'b0101, 4'b0000); // ch2 ON
    add_vec(11500, 1, 4'd2,  3'd4, 1, 0, 4'b0001, 4'b0000); // mode 4 starts unlit
    add_vec(11600, 1, 4'd2,  3'd0, 0, 0, 4'b0001, 4'b0000); // ch2 OFF
    add_vec(15999, 0, 4'd0,  3'd0, 0, 0, 4'b0000, 4'b0000); // ch1 still in gap
    add_vec(16000, 0, 4'd0,  3'd0, 0, 0, 4'b0010, 4'b0010); // gap end pulse
    add_vec(16001, 0, 4'd0,  3'd0, 0, 0, 4'b0010, 4'b0000); // pulse is one cycle
    add_vec(17000, 0, 4'd0,  3'd0, 0, 0, 4'b0011, 4'b0000);
    add_vec(18000, 0, 4'd0,  3'd0, 0, 0, 4'b0001, 4'b0000); // ch1 pattern repeats
    run_vecs();

    // Async reset in the middle of a running pattern.
    while (edge_cnt + 1 < 18500) @(negedge clk);
    @(posedge clk);
    #1;
    check4("pre_reset_led", 18500, led, 4'b0001);
    #2;
    rst_n = 1'b0;
    #1;
    check4("async_reset_led", 18500, led, 4'b0000);
    check4("async_reset_led_inv", 18500, led_n, 4'b1111);
    check4("async_reset_seq_done", 18500, seq_done, 4'b0000);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Nothing resumes after release; then a single-flash 1 ms sequence.
    vecs.delete();
    add_vec(2500, 0, 4'd0, 3'd0, 0, 0, 4'b0000, 4'b0000);
    add_vec(2600, 1, 4'd1, 3'd3, 1, 1, 4'b0010, 4'b0000);
    add_vec(2999, 0, 4'd0, 3'd0, 0, 0, 4'b0010, 4'b0000);
    add_vec(3000, 0, 4'd0, 3'd0, 0, 0, 4'b0000, 4'b0000);
    add_vec(4000, 0, 4'd0, 3'd0, 0, 0, 4'b0000, 4'b0000);
    add_vec(7999, 0, 4'd0, 3'd0, 0, 0, 4'b0000, 4'b0000);
    add_vec(8000, 0, 4'd0, 3'd0, 0, 0, 4'b0010, 4'b0010);
    add_vec(8001, 0, 4'd0, 3'd0, 0, 0, 4'b0010, 4'b0000);
    add_vec(8500, 1, 4'd0, 3'd4, 9, 0, 4'b0010, 4'b0000); // ch0 mode 4
    run_vecs();

`ifdef LED_BREATHE_EN
    // PWM_BITS=4 copy: duty after tick k (ticks at 9000, 10000, ...).
    while (edge_cnt < 23100) @(negedge clk);
    lit_cycles(n); check_int("breathe_duty_t15", n, 15);
    while (edge_cnt < 24100) @(negedge clk);
    lit_cycles(n); check_int("breathe_duty_t16", n, 14);
    while (edge_cnt < 38100) @(negedge clk);
    lit_cycles(n); check_int("breathe_duty_t30", n, 0);
    while (edge_cnt < 39100) @(negedge clk);
    lit_cycles(n); check_int("breathe_duty_t31", n, 1);
    check4("breathe_seq_done", edge_cnt, seq_done_b & 4'b0001, 4'b0000);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
